// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and round-robin helper for the uart transmit scheduler
package uart_sched_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int MAX_REQ    = 4;

  typedef enum logic {IDLE, SEND} state_e;

  // First set bit of mask scanning last+1, last+2, ... modulo n; 0 when mask is empty.
  function automatic logic [1:0] rr_next(input logic [1:0] last,
                                         input logic [MAX_REQ-1:0] mask,
                                         input int n);
    logic [1:0] res;
    logic       hit;
    int         k;
    res = '0;
    hit = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      k = (int'(last) + i) % n;
      if (i <= n && !hit && mask[k[1:0]]) begin
        res = k[1:0];
        hit = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - small per-requester byte FIFO, registered head, no fall-through
module byte_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx among several byte producers
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = DATA_W_DEF,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_data_valid,
  input  logic                      tx_ready,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
);

  logic [DATA_W-1:0]  head [NUM_REQ];
  logic [NUM_REQ-1:0] empty, full, pop_vec;
  logic [MAX_REQ-1:0] ne_mask;
  logic [GW-1:0]      pick_idx;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               valid_q, valid_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    byte_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid[i]),
      .din   (req_data[i*DATA_W +: DATA_W]),
      .pop   (pop_vec[i]),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  assign req_ready = ~full;

  always_comb begin
    ne_mask = '0;
    ne_mask[NUM_REQ-1:0] = ~empty;
  end

  assign pick_idx = GW'(rr_next(2'(last_grant_q), ne_mask, NUM_REQ));

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    valid_d      = valid_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pop_vec      = '0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (|ne_mask) begin
          pop_vec[pick_idx] = 1'b1;
          tx_data_d         = head[pick_idx];
          grant_d           = pick_idx;
          valid_d           = 1'b1;
          state_d           = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          valid_d      = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      valid_q      <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      valid_q      <= valid_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = valid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == SEND) || (|ne_mask);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed scoreboard bench for uart_tx_sched
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_ready;
  logic [0:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb [$];

  uart_tx_sched #(.NUM_REQ(2), .FIFO_DEPTH(4), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    req_data  = '0;
    tx_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push2(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_data  = {d1, d0};
    tick();
    req_valid = 2'b00;
  endtask

  task automatic expect_xfer(input string tag);
    logic [8:0] e;
    logic       done;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (tx_data_valid && tx_ready) begin
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk(tag, {23'd0, grant_id, tx_data}, {23'd0, e});
        end
        done = 1'b1;
      end
      tick();
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic stable_ok;

    // 1: reset then idle
    do_reset();
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd3);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_data_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b11) stable_ok = 1'b0;
    end
    chk("idle_20", 32'(stable_ok), 32'd1);

    // 2: single byte latency
    tx_ready = 1'b1;
    push2(2'b01, 8'h41, 8'h00);
    chk("lat_t1_valid", 32'(tx_data_valid), 32'd0);
    chk("lat_t1_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_t2_valid", 32'(tx_data_valid), 32'd1);
    sb.push_back({1'b0, 8'h41});
    expect_xfer("single");
    stable_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (tx_data_valid !== 1'b0) stable_ok = 1'b0;
      tick();
    end
    chk("single_once", 32'(stable_ok), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);

    // 3: fairness
    do_reset();
    push2(2'b11, 8'hA0, 8'hB0);
    push2(2'b11, 8'hA1, 8'hB1);
    push2(2'b11, 8'hA2, 8'hB2);
    sb.push_back({1'b0, 8'hA0}); sb.push_back({1'b1, 8'hB0});
    sb.push_back({1'b0, 8'hA1}); sb.push_back({1'b1, 8'hB1});
    sb.push_back({1'b0, 8'hA2}); sb.push_back({1'b1, 8'hB2});
    tx_ready = 1'b1;
    for (int k = 0; k < 6; k++) expect_xfer("rr_order");
    chk("rr_sb_drained", 32'(sb.size()), 32'd0);

    // 4: backpressure and full FIFO
    do_reset();
    push2(2'b01, 8'hC0, 8'h00);
    tick();
    chk("bp_valid", 32'(tx_data_valid), 32'd1);
    push2(2'b01, 8'hC1, 8'h00);
    push2(2'b01, 8'hC2, 8'h00);
    push2(2'b01, 8'hC3, 8'h00);
    push2(2'b01, 8'hC4, 8'h00);
    chk("bp_full_ready", 32'(req_ready), 32'd2);
    req_valid = 2'b01;
    req_data  = {8'h00, 8'hC5};
    tick(); tick(); tick();
    chk("bp_still_full", 32'(req_ready), 32'd2);
    req_valid = 2'b00;
    stable_ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (tx_data !== 8'hC0 || grant_id !== 1'b0 || tx_data_valid !== 1'b1) stable_ok = 1'b0;
      tick();
    end
    chk("bp_stable50", 32'(stable_ok), 32'd1);
    for (int k = 0; k < 5; k++) sb.push_back({1'b0, 8'hC0 + 8'(k)});
    tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) expect_xfer("bp_order");
    tick(); tick();
    chk("bp_no_extra_valid", 32'(tx_data_valid), 32'd0);
    chk("bp_busy_done", 32'(busy), 32'd0);

    // 5: push into a full FIFO while its head is popped
    do_reset();
    for (int k = 0; k < 5; k++) push2(2'b10, 8'h00, 8'hD0 + 8'(k));
    chk("ff_full", 32'(req_ready[1]), 32'd0);
    req_valid = 2'b10;
    req_data  = {8'hD5, 8'h00};
    for (int k = 0; k < 6; k++) sb.push_back({1'b1, 8'hD0 + 8'(k)});
    tx_ready = 1'b1;
    expect_xfer("ff_d0");
    chk("ff_ready_still0", 32'(req_ready[1]), 32'd0);
    tick();
    chk("ff_ready_back", 32'(req_ready[1]), 32'd1);
    expect_xfer("ff_d1");
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) expect_xfer("ff_rest");
    tick(); tick();
    chk("ff_no_extra", 32'(tx_data_valid), 32'd0);

    // 6: reset mid-SEND
    do_reset();
    push2(2'b10, 8'h00, 8'hE0);
    tick();
    push2(2'b11, 8'hF0, 8'hE1);
    push2(2'b01, 8'hF1, 8'h00);
    chk("mid_valid_pre", 32'(tx_data_valid), 32'd1);
    chk("mid_grant_pre", 32'(grant_id), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_valid", 32'(tx_data_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd3);
    rst = 1'b0;
    push2(2'b11, 8'h60, 8'h61);
    sb.push_back({1'b0, 8'h60});
    sb.push_back({1'b1, 8'h61});
    tx_ready = 1'b1;
    expect_xfer("mid_first");
    expect_xfer("mid_second");
    tick(); tick();
    chk("mid_busy_end", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
